// File: rtl/l2_qos_shaper.sv
// Purpose : per-class token-bucket shaper with round-robin arbitration and credit-gated issue to an L2 bank.
// Latency : a grant is visible on out_valid/out_class/out_len one cycle after req_ready pulses.
// Backpressure: a stalled issue slot (out_valid & !out_ready) or zero credits blocks every grant.
//
// Ports:
//   clk, reset              : single rising-edge clock, synchronous active-high reset
//   req_valid/req_len_flat  : per-class head-of-queue valid and length (beats), class 0 in LSBs
//   req_ready               : one-hot pop strobe for the granted class (combinational)
//   rate_flat/burst_flat    : per-class refill amount and token cap, sampled at refill ticks
//   refill_period           : cycles between refill ticks (0 behaves as 1)
//   out_valid/class/len     : issue slot towards the bank, accepted on out_valid & out_ready
//   cred_return             : one bank credit returned this cycle
//   credits_avail           : current bank credit count
//   tokens_flat             : registered per-class token counts
//   cred_overflow           : sticky flag, a credit came back while already full
module l2_qos_shaper #(
  parameter int C        = 4,
  parameter int LEN_W    = 12,
  parameter int TOK_W    = 16,
  parameter int MAX_CRED = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [C-1:0]           req_valid,
  input  logic [C*LEN_W-1:0]     req_len_flat,
  output logic [C-1:0]           req_ready,
  input  logic [C*TOK_W-1:0]     rate_flat,
  input  logic [C*TOK_W-1:0]     burst_flat,
  input  logic [15:0]            refill_period,
  output logic                   out_valid,
  output logic [$clog2(C)-1:0]   out_class,
  output logic [LEN_W-1:0]       out_len,
  input  logic                   out_ready,
  input  logic                   cred_return,
  output logic [7:0]             credits_avail,
  output logic [C*TOK_W-1:0]     tokens_flat,
  output logic                   cred_overflow
);

  localparam int         CW    = $clog2(C);
  localparam logic [7:0] MAX_C = 8'(MAX_CRED);

  // Registered state
  logic [15:0]      r_timer;
  logic [TOK_W-1:0] r_tok [C];
  logic [7:0]       r_cred;
  logic             r_ovf;
  logic [CW-1:0]    r_ptr;
  logic             r_out_valid;
  logic [CW-1:0]    r_out_class;
  logic [LEN_W-1:0] r_out_len;

  // Combinational helpers
  logic [LEN_W-1:0] w_len   [C];
  logic [TOK_W-1:0] w_rate  [C];
  logic [TOK_W-1:0] w_burst [C];
  logic [15:0]      w_period_m1;
  logic             w_tick;
  logic             w_slot_free;
  logic [C-1:0]     w_elig;
  logic             w_gnt_vld;
  logic [CW-1:0]    w_gnt_idx;
  logic [CW-1:0]    w_idx;
  logic [TOK_W:0]   w_after_gnt [C];
  logic [TOK_W:0]   w_refill    [C];
  logic [TOK_W-1:0] w_tok_nxt   [C];
  logic [7:0]       w_cred_nxt;
  logic             w_ovf_set;

  always_comb begin
    for (int c = 0; c < C; c++) begin
      w_len[c]   = req_len_flat[c*LEN_W +: LEN_W];
      w_rate[c]  = rate_flat[c*TOK_W +: TOK_W];
      w_burst[c] = burst_flat[c*TOK_W +: TOK_W];
    end
  end

  // Refill timer. The >= compare lets the timer recover at once if
  // refill_period is lowered below the current count.
  assign w_period_m1 = (refill_period == 16'd0) ? 16'd0 : refill_period - 16'd1;
  assign w_tick      = (r_timer >= w_period_m1);

  // The issue slot can take a new request if empty or draining this cycle.
  assign w_slot_free = !r_out_valid || out_ready;

  always_comb begin
    for (int c = 0; c < C; c++) begin
      w_elig[c] = req_valid[c]
                  && (r_tok[c] >= TOK_W'(w_len[c]))
                  && (r_cred != 8'd0)
                  && w_slot_free
                  && !reset;
    end
  end

  // Round-robin: first eligible class at or above r_ptr, wrapping modulo C
  // (C is a power of two so the CW-bit add wraps naturally).
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int i = 0; i < C; i++) begin
      w_idx = r_ptr + CW'(i);
      if (!w_gnt_vld && w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_gnt_vld) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Token update: debit the grant first, then refill and clamp on a tick.
  // One extra bit keeps the refill sum from wrapping before the clamp.
  always_comb begin
    for (int c = 0; c < C; c++) begin
      w_after_gnt[c] = {1'b0, r_tok[c]}
                       - ((w_gnt_vld && (w_gnt_idx == CW'(c))) ? (TOK_W+1)'(w_len[c])
                                                               : {(TOK_W+1){1'b0}});
      w_refill[c]    = w_after_gnt[c] + {1'b0, w_rate[c]};
      if (w_tick) begin
        w_tok_nxt[c] = (w_refill[c] > {1'b0, w_burst[c]}) ? w_burst[c]
                                                          : w_refill[c][TOK_W-1:0];
      end else begin
        w_tok_nxt[c] = w_after_gnt[c][TOK_W-1:0];
      end
    end
  end

  // Credits: a grant and a return in the same cycle cancel out.
  always_comb begin
    w_cred_nxt = r_cred;
    w_ovf_set  = 1'b0;
    case ({w_gnt_vld, cred_return})
      2'b10: w_cred_nxt = r_cred - 8'd1;
      2'b01: begin
        if (r_cred == MAX_C) begin
          w_ovf_set = 1'b1;
        end else begin
          w_cred_nxt = r_cred + 8'd1;
        end
      end
      default: w_cred_nxt = r_cred;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer     <= 16'd0;
      r_cred      <= MAX_C;
      r_ovf       <= 1'b0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_len   <= '0;
      for (int c = 0; c < C; c++) begin
        r_tok[c] <= '0;
      end
    end else begin
      r_timer <= w_tick ? 16'd0 : r_timer + 16'd1;
      r_cred  <= w_cred_nxt;
      r_ovf   <= r_ovf | w_ovf_set;
      for (int c = 0; c < C; c++) begin
        r_tok[c] <= w_tok_nxt[c];
      end
      if (w_gnt_vld) begin
        r_ptr       <= w_gnt_idx + CW'(1);
        r_out_valid <= 1'b1;
        r_out_class <= w_gnt_idx;
        r_out_len   <= w_len[w_gnt_idx];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    tokens_flat = '0;
    for (int c = 0; c < C; c++) begin
      tokens_flat[c*TOK_W +: TOK_W] = r_tok[c];
    end
  end

  assign out_valid     = r_out_valid;
  assign out_class     = r_out_class;
  assign out_len       = r_out_len;
  assign credits_avail = r_cred;
  assign cred_overflow = r_ovf;

endmodule

// File: tb/tb_l2_qos_shaper.sv
// Scoreboard bench for l2_qos_shaper: a cycle reference model built from the
// token-bucket / round-robin / credit rules pushes expected issues into a
// queue; a separate monitor pops and compares on every out_valid&out_ready.
module tb_l2_qos_shaper;
  localparam int C        = 4;
  localparam int LEN_W    = 12;
  localparam int TOK_W    = 16;
  localparam int MAX_CRED = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [C-1:0]         req_valid = '0;
  logic [C*LEN_W-1:0]   req_len_flat = '0;
  logic [C-1:0]         req_ready;
  logic [C*TOK_W-1:0]   rate_flat = '0;
  logic [C*TOK_W-1:0]   burst_flat = '0;
  logic [15:0]          refill_period = 16'd4;
  logic                 out_valid;
  logic [1:0]           out_class;
  logic [LEN_W-1:0]     out_len;
  logic                 out_ready = 1'b1;
  logic                 cred_return = 1'b0;
  logic [7:0]           credits_avail;
  logic [C*TOK_W-1:0]   tokens_flat;
  logic                 cred_overflow;

  l2_qos_shaper #(.C(C), .LEN_W(LEN_W), .TOK_W(TOK_W), .MAX_CRED(MAX_CRED)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_len_flat(req_len_flat), .req_ready(req_ready),
    .rate_flat(rate_flat), .burst_flat(burst_flat), .refill_period(refill_period),
    .out_valid(out_valid), .out_class(out_class), .out_len(out_len), .out_ready(out_ready),
    .cred_return(cred_return), .credits_avail(credits_avail),
    .tokens_flat(tokens_flat), .cred_overflow(cred_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus-side configuration
  int len_a [C];
  int rate_a [C];
  int burst_a [C];

  // Reference model state
  int m_tok [C];
  int m_cred;
  int m_ptr;
  int m_cyc;
  bit m_ovf;
  bit m_out_vld;

  typedef struct { int cls; int len; } item_t;
  item_t exp_q[$];
  item_t seen[$];

  task automatic model_eval();
    int p;
    int g;
    int c;
    bit tick;
    if (reset) begin
      chk("req_ready_in_reset", req_ready, 0);
      for (int k = 0; k < C; k++) m_tok[k] = 0;
      m_cred = MAX_CRED; m_ptr = 0; m_cyc = 0; m_ovf = 0; m_out_vld = 0;
      exp_q.delete();
      return;
    end
    chk("credits_avail", credits_avail, m_cred);
    chk("cred_overflow", cred_overflow, m_ovf);
    chk("out_valid", out_valid, m_out_vld);
    for (int k = 0; k < C; k++)
      chk($sformatf("tokens[%0d]", k), tokens_flat[k*TOK_W +: TOK_W], m_tok[k]);

    p    = (refill_period == 0) ? 1 : int'(refill_period);
    tick = ((m_cyc % p) == p - 1);
    g    = -1;
    for (int k = 0; k < C; k++) begin
      c = (m_ptr + k) % C;
      if (g < 0 && req_valid[c] && m_tok[c] >= len_a[c] && m_cred > 0 &&
          (!m_out_vld || out_ready))
        g = c;
    end
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));

    if (g >= 0) begin
      exp_q.push_back('{cls: g, len: len_a[g]});
      m_tok[g] -= len_a[g];
      m_ptr     = (g + 1) % C;
      m_out_vld = 1;
    end else if (out_ready) begin
      m_out_vld = 0;
    end
    if (tick)
      for (int k = 0; k < C; k++)
        m_tok[k] = (m_tok[k] + rate_a[k] > burst_a[k]) ? burst_a[k] : m_tok[k] + rate_a[k];
    if (g >= 0 && !cred_return) m_cred--;
    else if (g < 0 && cred_return) begin
      if (m_cred == MAX_CRED) m_ovf = 1;
      else m_cred++;
    end
    m_cyc++;
  endtask

  // Called at a falling edge with inputs already chosen.
  task automatic step();
    for (int k = 0; k < C; k++) begin
      req_len_flat[k*LEN_W +: LEN_W] = LEN_W'(len_a[k]);
      rate_flat[k*TOK_W +: TOK_W]    = TOK_W'(rate_a[k]);
      burst_flat[k*TOK_W +: TOK_W]   = TOK_W'(burst_a[k]);
    end
    #1;
    model_eval();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  task automatic set_all(input int l, input int r, input int b);
    for (int k = 0; k < C; k++) begin
      len_a[k] = l; rate_a[k] = r; burst_a[k] = b;
    end
  endtask

  // Monitor: pops the scoreboard on every accepted issue, checks holds under stall.
  bit prev_stall = 0;
  int prev_cls = 0;
  int prev_len = 0;
  always @(negedge clk) begin
    item_t it;
    #1;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_class", out_class, prev_cls);
        chk("stall_out_len", out_len, prev_len);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got class %0d len %0d, expected none", out_class, out_len);
        end else begin
          it = exp_q.pop_front();
          chk("out_class", out_class, it.cls);
          chk("out_len", out_len, it.len);
        end
        seen.push_back('{cls: int'(out_class), len: int'(out_len)});
      end
      prev_stall = out_valid && !out_ready;
      prev_cls   = int'(out_class);
      prev_len   = int'(out_len);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit hit;
    set_all(8, 8, 32);
    @(negedge clk);

    // Reset, then round robin after the first tick, then credit exhaustion.
    req_valid = 4'hF; refill_period = 16'd4; out_ready = 1'b1;
    do_reset(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_credits", credits_avail, 8);
    chk("rst_tokens", tokens_flat, 0);
    seen.delete();
    run(40);
    chk("rr_grant_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      chk($sformatf("rr_class_%0d", i), seen[i].cls, i % C);
      chk($sformatf("rr_len_%0d", i), seen[i].len, 8);
    end
    chk("cred_exhausted", credits_avail, 0);
    chk("cred_exhausted_rdy", req_ready, 0);
    cred_return = 1'b1; step(); cred_return = 1'b0;
    run(10);
    chk("one_more_grant", seen.size(), 9);

    // Backpressure: hold the issue slot for 10 cycles.
    out_ready = 1'b0;
    cred_return = 1'b1; run(3); cred_return = 1'b0;
    n = seen.size();
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    out_ready = 1'b1;
    run(5);
    chk("bp_release_count", seen.size(), n + 3);

    // Burst cap.
    set_all(51, 100, 50);
    req_valid = 4'h1; refill_period = 16'd4;
    do_reset(2);
    n = seen.size();
    run(20);
    chk("burst_cap_tokens", tokens_flat[TOK_W-1:0], 50);
    chk("len_over_burst_no_grant", seen.size(), n);
    len_a[0] = 50;
    step();
    req_valid = 4'h0;
    step();
    chk("burst_drained_tokens", tokens_flat[TOK_W-1:0], 0);
    run(3);
    chk("burst_grant_count", seen.size(), n + 1);
    if (seen.size() > 0) chk("burst_grant_len", seen[seen.size()-1].len, 50);

    // Simultaneous grant/return and overflow at full credits.
    set_all(1, 100, 100);
    req_valid = 4'h0; refill_period = 16'd1;
    do_reset(2);
    cred_return = 1'b1; step(); cred_return = 1'b0;
    chk("ovf_credits", credits_avail, 8);
    chk("ovf_flag", cred_overflow, 1);
    req_valid = 4'h1;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (credits_avail == 8'd1) begin
        cred_return = 1'b1; step(); cred_return = 1'b0; req_valid = 4'h0;
        hit = 1;
        break;
      end
      step();
    end
    chk("reached_one_credit", hit, 1);
    chk("grant_and_return_credits", credits_avail, 1);

    // Randomized traffic with a mid-run reset.
    refill_period = 16'($urandom_range(0, 5));
    for (int k = 0; k < C; k++) begin
      rate_a[k]  = $urandom_range(0, 20);
      burst_a[k] = $urandom_range(20, 60);
      len_a[k]   = $urandom_range(1, 40);
    end
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      reset       = (i == 1500);
      req_valid   = C'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      cred_return = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < C; k++) begin
        if ($urandom_range(0, 3) == 0) len_a[k] = $urandom_range(1, 40);
        if ($urandom_range(0, 99) == 0) rate_a[k] = $urandom_range(0, 20);
      end
      step();
    end
    reset = 1'b0; req_valid = '0; out_ready = 1'b1; cred_return = 1'b0;
    run(4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
